// File: rtl/fifo_rd_pkg.sv
// Shared types and constants for the async-FIFO read-side drain engine.
// Burst FSM states, default payload window and error-counter sizing.
package fifo_rd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } rd_state_e;

    localparam int DEF_LO = 29;
    localparam int DEF_HI = 102;
    localparam int ERR_CW = 8;

    localparam logic [ERR_CW-1:0] ERR_MAX = '1;

    function automatic logic out_of_window(
        input logic [31:0] v,
        input logic [31:0] lo,
        input logic [31:0] hi
    );
        return (v < lo) || (v > hi);
    endfunction

endpackage

// File: rtl/fifo_rd_drain_skid.sv
// Two-entry skid buffer between FIFO read data and the output stream.
// Count and pointers reset; payload storage is left uninitialised.
module rd_skid_buf #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [DW-1:0] head,
    output logic [1:0]    count
);

    logic [DW-1:0] mem_q [2];
    logic [DW-1:0] mem_d [2];
    logic          wr_ptr_q;
    logic          wr_ptr_d;
    logic          rd_ptr_q;
    logic          rd_ptr_d;
    logic [1:0]    cnt_q;
    logic [1:0]    cnt_d;
    logic          pop_ok;
    logic          push_ok;

    assign pop_ok  = pop & (cnt_q != 2'd0);
    assign push_ok = push & ((cnt_q != 2'd2) | pop_ok);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop_ok) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        cnt_d = cnt_q + 2'(push_ok) - 2'(pop_ok);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = cnt_q;

endmodule

// File: rtl/fifo_rd_drain.sv
// Read-domain burst drain: pops N words from the async FIFO, range-checks
// each one and forwards it on a valid/ready stream through a skid buffer.
module fifo_rd_drain
    import fifo_rd_pkg::*;
#(
    parameter int DW  = 8,
    parameter int LO  = DEF_LO,
    parameter int HI  = DEF_HI,
    parameter int BLW = 8
) (
    input  logic           rclk,
    input  logic           rreset,
    input  logic           start,
    input  logic [BLW-1:0] burst_len,
    input  logic           err_clr,
    input  logic           rempty,
    output logic           re,
    input  logic [DW-1:0]  dataout,
    output logic           m_valid,
    output logic [DW-1:0]  m_data,
    input  logic           m_ready,
    output logic           busy,
    output logic           done,
    output logic           range_err,
    output logic [7:0]     err_cnt
);

    rd_state_e         state_q;
    rd_state_e         state_d;
    logic [BLW-1:0]    remaining_q;
    logic [BLW-1:0]    remaining_d;
    logic              rd_pending_q;
    logic              rd_pending_d;
    logic              busy_q;
    logic              busy_d;
    logic              done_q;
    logic              done_d;
    logic              range_err_q;
    logic              range_err_d;
    logic [ERR_CW-1:0] err_cnt_q;
    logic [ERR_CW-1:0] err_cnt_d;

    logic [1:0]        buf_cnt;
    logic [DW-1:0]     buf_head;
    logic              pop;
    logic              space_ok;
    logic              cap_bad;

    rd_skid_buf #(
        .DW(DW)
    ) u_buf (
        .clk       (rclk),
        .rst       (rreset),
        .push      (rd_pending_q),
        .push_data (dataout),
        .pop       (pop),
        .head      (buf_head),
        .count     (buf_cnt)
    );

    assign m_valid = (buf_cnt != 2'd0);
    assign pop     = m_valid & m_ready;
    assign m_data  = m_valid ? buf_head : '0;

    // Room for one more word once buffered and in-flight words are counted.
    assign space_ok = ({1'b0, buf_cnt} + {2'b00, rd_pending_q})
                    < (3'd2 + {2'b00, pop});

    assign cap_bad = rd_pending_q
                   & out_of_window(32'(dataout), 32'(LO), 32'(HI));

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        re          = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (burst_len != '0) begin
                        remaining_d = burst_len;
                        state_d     = READ;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            READ: begin
                re = !rempty && (remaining_q != '0) && space_ok;
                if (re) begin
                    remaining_d = remaining_q - BLW'(1);
                    if (remaining_q == BLW'(1)) begin
                        state_d = FLUSH;
                    end
                end
            end
            FLUSH: begin
                if (!rd_pending_q && (buf_cnt == 2'd0)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        rd_pending_d = re;
        busy_d       = (state_q == READ) || (state_q == FLUSH);
        done_d       = (state_q == DONE);
    end

    // A clear that coincides with a bad capture still records that capture.
    always_comb begin
        range_err_d = range_err_q;
        err_cnt_d   = err_cnt_q;
        if (err_clr) begin
            range_err_d = cap_bad;
            err_cnt_d   = cap_bad ? ERR_CW'(1) : '0;
        end else if (cap_bad) begin
            range_err_d = 1'b1;
            if (err_cnt_q != ERR_MAX) begin
                err_cnt_d = err_cnt_q + ERR_CW'(1);
            end
        end
    end

    always_ff @(posedge rclk or posedge rreset) begin
        if (rreset) begin
            state_q      <= IDLE;
            remaining_q  <= '0;
            rd_pending_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            range_err_q  <= 1'b0;
            err_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            remaining_q  <= remaining_d;
            rd_pending_q <= rd_pending_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            range_err_q  <= range_err_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign range_err = range_err_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_fifo_rd_drain.sv
// Self-checking bench for fifo_rd_drain: FIFO source model, stream sink,
// table-driven range bursts, hand-written corner sequences and random bursts.
module tb_fifo_rd_drain;

    localparam int DW  = 8;
    localparam int BLW = 8;
    localparam int LO  = 29;
    localparam int HI  = 102;

    logic           rclk = 1'b0;
    logic           rreset;
    logic           start;
    logic [BLW-1:0] burst_len;
    logic           err_clr;
    logic           rempty;
    logic           re;
    logic [DW-1:0]  dataout = '0;
    logic           m_valid;
    logic [DW-1:0]  m_data;
    logic           m_ready;
    logic           busy;
    logic           done;
    logic           range_err;
    logic [7:0]     err_cnt;

    fifo_rd_drain #(
        .DW(DW), .LO(LO), .HI(HI), .BLW(BLW)
    ) dut (
        .rclk      (rclk),
        .rreset    (rreset),
        .start     (start),
        .burst_len (burst_len),
        .err_clr   (err_clr),
        .rempty    (rempty),
        .re        (re),
        .dataout   (dataout),
        .m_valid   (m_valid),
        .m_data    (m_data),
        .m_ready   (m_ready),
        .busy      (busy),
        .done      (done),
        .range_err (range_err),
        .err_cnt   (err_cnt)
    );

    always #5 rclk = ~rclk;

    // Source FIFO model and sink scoreboard.
    logic [DW-1:0] fmem [0:4095];
    logic [DW-1:0] gmem [0:4095];
    int   wr_i = 0;
    int   rd_i = 0;
    int   g_i = 0;
    int   re_cnt = 0;
    int   done_cnt = 0;
    int   ovf = 0;
    int   stab_err = 0;
    logic stall = 1'b0;
    logic hold_pend = 1'b0;
    logic [DW-1:0] hold_d = '0;

    assign rempty = stall || (rd_i >= wr_i);

    always @(posedge rclk) begin
        if (re) begin
            dataout <= fmem[rd_i];
            rd_i    <= rd_i + 1;
            re_cnt  <= re_cnt + 1;
        end
        if (m_valid && m_ready) begin
            gmem[g_i] <= m_data;
            g_i       <= g_i + 1;
        end
        if (done) done_cnt <= done_cnt + 1;
        if (rreset) begin
            hold_pend <= 1'b0;
        end else begin
            if (hold_pend && !(m_valid && m_data == hold_d))
                stab_err <= stab_err + 1;
            hold_pend <= m_valid && !m_ready;
            hold_d    <= m_data;
        end
    end

    always @(negedge rclk) begin
        if (dut.buf_cnt == 2'd3) ovf <= ovf + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    int total = 0;
    int bad = 0;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic push_w(input logic [DW-1:0] w);
        fmem[wr_i] = w;
        wr_i = wr_i + 1;
    endtask

    task automatic start_burst(input int len);
        start = 1'b1;
        burst_len = BLW'(len);
        @(negedge rclk);
        start = 1'b0;
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        @(negedge rclk);
        err_clr = 1'b0;
    endtask

    task automatic wait_done(input int budget, input bit rnd);
        int d0;
        d0 = done_cnt;
        for (int k = 0; k < budget; k++) begin
            if (done_cnt > d0) break;
            if (rnd) begin
                m_ready = 1'($urandom_range(0, 1));
                stall = ($urandom_range(0, 3) == 0);
            end
            @(negedge rclk);
        end
        stall = 1'b0;
        m_ready = 1'b1;
        repeat (2) @(negedge rclk);
        chk("done_once", done_cnt - d0, 1);
    endtask

    typedef struct {
        int            len;
        logic [DW-1:0] w [4];
        int            ecnt;
        int            eerr;
    } vec_t;

    vec_t tbl [5];

    initial begin
        logic [9:0] rtr, vtr, dtr;
        logic [DW-1:0] dat [10];
        logic [3:0] ztr, zbusy;
        logic [DW-1:0] wq [16];
        int r0, h0, sbad, mism, len, exp_bad;

        tbl[0].len = 4; tbl[0].w = '{8'd28, 8'd29, 8'd102, 8'd103};
        tbl[0].ecnt = 2; tbl[0].eerr = 1;
        tbl[1].len = 4; tbl[1].w = '{8'd0, 8'd255, 8'd30, 8'd100};
        tbl[1].ecnt = 2; tbl[1].eerr = 1;
        tbl[2].len = 3; tbl[2].w = '{8'd29, 8'd102, 8'd60, 8'd0};
        tbl[2].ecnt = 0; tbl[2].eerr = 0;
        tbl[3].len = 1; tbl[3].w = '{8'd250, 8'd0, 8'd0, 8'd0};
        tbl[3].ecnt = 1; tbl[3].eerr = 1;
        tbl[4].len = 2; tbl[4].w = '{8'd103, 8'd28, 8'd0, 8'd0};
        tbl[4].ecnt = 2; tbl[4].eerr = 1;

        rreset = 1'b1;
        start = 1'b0;
        burst_len = '0;
        err_clr = 1'b0;
        m_ready = 1'b1;
        repeat (2) @(negedge rclk);
        chk("reset_outs",
            int'({re, m_valid, m_data, busy, done, range_err, err_cnt}), 0);
        rreset = 1'b0;
        @(negedge rclk);

        // Basic burst timing
        for (int i = 30; i < 34; i++) push_w(DW'(i));
        r0 = done_cnt;
        start_burst(4);
        for (int i = 0; i < 10; i++) begin
            rtr[i] = re;
            vtr[i] = m_valid;
            dtr[i] = done;
            dat[i] = m_data;
            @(negedge rclk);
        end
        chk("basic_re", int'(rtr), int'(10'b0000001111));
        chk("basic_valid", int'(vtr), int'(10'b0000111100));
        for (int i = 0; i < 4; i++) chk("basic_data", int'(dat[i+2]), 30 + i);
        chk("basic_done_cnt", done_cnt - r0, 1);
        chk("basic_done_pos", int'(dtr), int'(10'b0100000000));
        chk("basic_busy_end", int'(busy), 0);
        chk("basic_range_err", int'(range_err), 0);

        // Backpressure
        for (int i = 30; i < 34; i++) push_w(DW'(i));
        m_ready = 1'b0;
        r0 = re_cnt;
        h0 = g_i;
        start_burst(4);
        repeat (6) @(negedge rclk);
        chk("bp_re_count", re_cnt - r0, 2);
        chk("bp_valid", int'(m_valid), 1);
        chk("bp_data", int'(m_data), 30);
        start_burst(7);
        @(negedge rclk);
        chk("bp_data_held", int'(m_data), 30);
        m_ready = 1'b1;
        wait_done(60, 1'b0);
        chk("bp_handshakes", g_i - h0, 4);
        for (int i = 0; i < 4; i++) chk("bp_order", int'(gmem[h0+i]), 30 + i);
        chk("bp_start_ignored", re_cnt - r0, 4);
        chk("bp_busy_end", int'(busy), 0);

        // Empty stall
        push_w(8'd40);
        h0 = g_i;
        start_burst(3);
        sbad = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge rclk);
            if (re !== 1'b0 || busy !== 1'b1) sbad++;
        end
        chk("stall_re0_busy1", sbad, 0);
        push_w(8'd41);
        push_w(8'd42);
        wait_done(60, 1'b0);
        chk("stall_words", g_i - h0, 3);
        for (int i = 0; i < 3; i++) chk("stall_order", int'(gmem[h0+i]), 40 + i);

        // Range boundaries, table-driven
        for (int t = 0; t < 5; t++) begin
            pulse_clr();
            h0 = g_i;
            for (int j = 0; j < tbl[t].len; j++) push_w(tbl[t].w[j]);
            start_burst(tbl[t].len);
            wait_done(60, 1'b0);
            chk("tbl_err_cnt", int'(err_cnt), tbl[t].ecnt);
            chk("tbl_range_err", int'(range_err), tbl[t].eerr);
            chk("tbl_fwd_cnt", g_i - h0, tbl[t].len);
            mism = 0;
            for (int j = 0; j < tbl[t].len; j++)
                if (gmem[h0+j] !== tbl[t].w[j]) mism++;
            chk("tbl_fwd_data", mism, 0);
        end

        // err_clr coincident with a bad capture
        push_w(8'd200);
        start_burst(1);
        @(negedge rclk);
        err_clr = 1'b1;
        @(negedge rclk);
        err_clr = 1'b0;
        chk("clr_coincide_cnt", int'(err_cnt), 1);
        chk("clr_coincide_err", int'(range_err), 1);
        wait_done(60, 1'b0);
        pulse_clr();
        chk("clr_cnt", int'(err_cnt), 0);
        chk("clr_err", int'(range_err), 0);

        // Counter saturation
        for (int i = 0; i < 255; i++) push_w(8'd5);
        start_burst(255);
        wait_done(700, 1'b0);
        chk("sat_255", int'(err_cnt), 255);
        for (int i = 0; i < 3; i++) push_w(8'd250);
        start_burst(3);
        wait_done(60, 1'b0);
        chk("sat_hold", int'(err_cnt), 255);
        pulse_clr();

        // Zero length
        r0 = re_cnt;
        start_burst(0);
        for (int i = 0; i < 4; i++) begin
            ztr[i] = done;
            zbusy[i] = busy;
            @(negedge rclk);
        end
        chk("zero_done_pos", int'(ztr), int'(4'b0010));
        chk("zero_busy", int'(zbusy), 0);
        chk("zero_no_re", re_cnt - r0, 0);

        // Reset mid-burst
        push_w(8'd200); push_w(8'd201); push_w(8'd50); push_w(8'd60);
        m_ready = 1'b0;
        start_burst(4);
        repeat (5) @(negedge rclk);
        chk("rst_pre_buf", int'(dut.buf_cnt), 2);
        chk("rst_pre_err", int'(err_cnt), 2);
        #1 rreset = 1'b1;
        #1;
        chk("rst_async", int'({re, m_valid, busy, err_cnt}), 0);
        @(negedge rclk);
        rreset = 1'b0;
        m_ready = 1'b1;
        @(negedge rclk);
        h0 = g_i;
        start_burst(2);
        wait_done(60, 1'b0);
        chk("rst_after_cnt", g_i - h0, 2);
        chk("rst_after_w0", int'(gmem[h0]), 50);
        chk("rst_after_w1", int'(gmem[h0+1]), 60);
        chk("rst_after_err", int'(err_cnt), 0);

        // Random bursts against a count/order reference
        for (int it = 0; it < 30; it++) begin
            pulse_clr();
            len = $urandom_range(0, 12);
            exp_bad = 0;
            h0 = g_i;
            for (int j = 0; j < len; j++) begin
                if ($urandom_range(0, 1) == 1)
                    wq[j] = DW'($urandom_range(LO, HI));
                else
                    wq[j] = DW'($urandom_range(0, 255));
                if (int'(wq[j]) < LO || int'(wq[j]) > HI) exp_bad++;
                push_w(wq[j]);
            end
            start_burst(len);
            wait_done(600, 1'b1);
            mism = 0;
            for (int j = 0; j < len; j++)
                if (gmem[h0+j] !== wq[j]) mism++;
            chk("rnd_count", g_i - h0, len);
            chk("rnd_data", mism, 0);
            chk("rnd_err_cnt", int'(err_cnt), exp_bad);
            chk("rnd_range_err", int'(range_err), int'(exp_bad != 0));
        end

        chk("buf_cnt_le2", ovf, 0);
        chk("stream_stable", stab_err, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fifo_rd_drain.md
Name: fifo_rd_drain

Overview:
- Read-side consumer of the asynchronous FIFO; lives entirely in the read clock domain.
- On a start command it pops a programmed number of words through re/dataout and forwards them on a valid/ready stream.
- Every popped word is range-checked against the legal payload window [LO:HI].
- Forms the read-end counterpart of the write-side traffic that the FIFO checkers monitor.

Parameters:
- DW, 8, data width of dataout and m_data.
- LO, 29, lowest legal payload value (inclusive).
- HI, 102, highest legal payload value (inclusive).
- BLW, 8, width of burst_len.

Ports:
- rclk  in  1  read-domain clock; all logic on posedge.
- rreset  in  1  reset, asynchronous, active-high.
- start  in  1  one-cycle burst request; sampled only in IDLE.
- burst_len  in  BLW  words to read; latched with start.
- err_clr  in  1  synchronous clear of range_err and err_cnt.
- rempty  in  1  FIFO empty flag (rclk domain).
- re  out  1  FIFO read enable.
- dataout  in  DW  FIFO read data; valid the cycle after re.
- m_valid  out  1  stream valid.
- m_data  out  DW  stream data.
- m_ready  in  1  stream ready.
- busy  out  1  burst in progress (READ or FLUSH).
- done  out  1  one-cycle burst-complete pulse.
- range_err  out  1  sticky; a word outside [LO:HI] was read.
- err_cnt  out  8  count of out-of-range words; saturates at 255.

Behaviour:
- Reset, asynchronous on rreset high:
  - state=IDLE.
  - re, m_valid, m_data, busy, done, range_err, err_cnt all 0.
  - Skid buffer empty; remaining=0; rd_pending=0.
  - Takes effect immediately, mid-burst included; in-flight data is discarded.
- States:
  - IDLE, start=1, burst_len!=0: latch remaining=burst_len, go to READ.
  - IDLE, start=1, burst_len=0: go to DONE with no FIFO access.
  - IDLE, start=0: stay in IDLE.
  - READ: issue reads; when the re that makes remaining reach 0 is issued, go to FLUSH.
  - FLUSH: wait until rd_pending=0 and buf_cnt=0, then go to DONE.
  - DONE: done=1 for exactly one cycle, then go to IDLE.
  - start while busy is ignored.
- Read issue:
  - re = (state==READ) & !rempty & (remaining!=0) & (space>=1).
  - space = 2 - buf_cnt - rd_pending + (m_valid & m_ready).
  - remaining decrements on every re.
  - rempty=1 stalls re indefinitely; busy stays 1.
- Read latency:
  - rd_pending is re registered.
  - When rd_pending=1, dataout is written into the 2-entry skid buffer at the end of that cycle.
  - First m_valid appears 2 cycles after the first re.
  - Steady-state throughput is 1 word/cycle with m_ready held at 1.
- Stream rules:
  - m_valid = (buf_cnt!=0); m_data = buffer head.
  - m_valid and m_data stay stable until m_valid & m_ready.
  - Order is preserved; no word is dropped or duplicated under any m_ready pattern.
  - Push and pop in the same cycle are legal.
  - Buffer overflow cannot occur by construction; the bench asserts buf_cnt<=2.
- Range check, evaluated at capture (rd_pending=1):
  - A word is out of range if dataout<LO or dataout>HI, unsigned compare.
  - Out of range: range_err<=1 and err_cnt<=err_cnt+1, saturating at 255.
  - The word is forwarded regardless.
  - err_clr alone: range_err<=0, err_cnt<=0.
  - err_clr with a simultaneous out-of-range capture: range_err<=1, err_cnt<=1.
- busy = (state==READ) | (state==FLUSH); registered from state.

Decomposition:
- Package fifo_rd_pkg holds:
  - state enum {IDLE, READ, FLUSH, DONE};
  - default LO/HI constants;
  - error-counter width constant (8).
- Sub-module rd_skid_buf: 2-entry synchronous FIFO with push/pop, head data, and count[1:0].
  - Shares rclk/rreset.
  - Reset clears count only; data contents are don't-care.

Test Plan:
- Basic burst: FIFO holds 30,31,32,33, m_ready=1, start with burst_len=4 -> re high for 4 consecutive cycles starting the cycle after start; m_data 30,31,32,33 on consecutive cycles starting 2 cycles after the first re; one done pulse; busy=0 afterwards; range_err=0.
- Backpressure: same data, m_ready=0 -> at most 2 re pulses issued; m_valid=1 with m_data=30 held stable. Raise m_ready -> remaining words arrive in order, 4 handshakes total, no loss.
- Empty stall: burst_len=3, rempty=1 after the first word for 5 cycles -> re=0 and busy=1 during the stall; the burst completes after rempty falls; done fires once.
- Range boundaries: words 28,29,102,103 -> range_err=1, err_cnt=2, all 4 words forwarded. Pulse err_clr -> range_err=0, err_cnt=0. Err_clr coincident with a capture of 200 -> err_cnt=1.
- Zero length: start with burst_len=0 -> no re; done pulses 2 cycles after start; busy stays 0.
- Reset mid-burst: assert rreset during READ with 2 words buffered -> re, m_valid, busy, err_cnt=0 immediately, without waiting for a clock edge. After release, start with burst_len=2 -> normal completion.
